dm_cache: RTL and testbench
===========================

# dm_cache

Direct-mapped, write-back, write-allocate cache that sits between `MIPS_Pipeline` and main memory. It is the responder for the processor's `ICACHE_*`/`DCACHE_*` interface, and one instance serves each port. Hits are answered in the request cycle. A miss raises `proc_stall` while a dirty victim block is written back and the missing block is fetched over a 128-bit memory handshake.

## Interface
- `INDEX_W`, default 3: index width, giving 2^INDEX_W blocks.
- Fixed geometry: 4 words per block; tag width `TAG_W` = 28 − INDEX_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `proc_addr` in 30: word address; [1:0] offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- `proc_ren` in 1: read request.
- `proc_wen` in 1: write request.
- `proc_wdata` in 32: write data.
- `proc_rdata` out 32: read data, valid when `proc_stall`=0.
- `proc_stall` out 1: request not yet serviced.
- `mem_addr` out 28: block address (word address >> 2).
- `mem_read` out 1: block fetch request.
- `mem_write` out 1: block write-back request.
- `mem_wdata` out 128: victim block; word i at [32i+31:32i].
- `mem_rdata` in 128: fetched block, same word order.
- `mem_ready` in 1: one-cycle pulse; the current memory transaction is complete.

## Operation
- Storage per block: valid bit, dirty bit, tag, 4×32 data.
- States: IDLE (compare), WRITEBACK, ALLOCATE.
- IDLE, no request (ren=wen=0): `proc_stall`=0, no memory activity.
- IDLE, request with tag match and valid set (hit):
  - `proc_stall`=0 in the same cycle.
  - Read: `proc_rdata` = addressed word, combinational.
  - Write: the word updates at the next edge and dirty is set.
- IDLE, miss: `proc_stall`=1 in the same cycle.
  - If valid and dirty → WRITEBACK.
  - Otherwise → ALLOCATE.
- WRITEBACK:
  - Drives `mem_write`=1, `mem_addr`={stored tag, index}, `mem_wdata`=stored block.
  - On `mem_ready` → ALLOCATE.
- ALLOCATE:
  - Drives `mem_read`=1, `mem_addr`=`proc_addr[29:2]`.
  - On `mem_ready`: line ← `mem_rdata`; tag written; valid=1; dirty=0; → IDLE.
  - The request then hits in IDLE. A write-miss merges its word on that hit cycle.
- `proc_stall`=1 throughout WRITEBACK and ALLOCATE.
- `mem_read`/`mem_write` are decoded from state only. They drop at the edge following `mem_ready`.
- ren and wen both high is treated as a write.
- The processor holds `proc_addr`/`proc_wen`/`proc_wdata` stable while stalled.
  - If the request is withdrawn mid-miss, the fill still completes and no processor write occurs.
- `mem_ready` outside WRITEBACK/ALLOCATE is ignored.
- `proc_rdata` is don't-care when not reading a hit; drive 0.

## Timing
- Reset (asynchronous): state=IDLE; all valid and dirty bits=0; `mem_read`=`mem_write`=0; `mem_addr`=0; `proc_stall` follows IDLE rules. Data and tag arrays are not reset.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: the memory request drops immediately and the line stays invalid.
- Hit latency: 0 cycles of stall.
- Clean miss, `mem_ready` seen in cycle k (miss detected in cycle 0): ALLOCATE cycles 1..k; IDLE hit with stall=0 at cycle k+1.
- Dirty miss: the WRITEBACK interval, then the same ALLOCATE sequence.
- No back-to-back memory transactions without an intervening state transition edge.

## Structure
- Package `cache_pkg`: state enum {IDLE, WRITEBACK, ALLOCATE}; `WORDS_PER_BLOCK`=4; `OFFSET_W`=2; block width 128.
- Sub-module `cache_line_array`: valid, dirty, tag and data storage.
  - Asynchronous read; synchronous write of either a full line (fill) or one word (write hit).
  - Valid and dirty are cleared by `rst_n`.
- Top module holds the FSM, hit compare and output muxing.

## Test plan
- Read miss, clean: after reset, read `proc_addr`=0x0 → stall=1, `mem_read`=1 with `mem_addr`=0; memory returns 128'h00000004_00000003_00000002_00000001 with `mem_ready` after 3 cycles → next cycle stall=0, `proc_rdata`=0x00000001.
- Read hit in the same block: read addr 0x1 → stall=0 in the same cycle, `proc_rdata`=0x00000002, no memory activity.
- Write hit: write 0xDEADBEEF to addr 0x2 → stall=0, no memory activity; a later read of 0x2 returns 0xDEADBEEF.
- Dirty conflict miss: read addr 0x20 (index 0, new tag):
  - `mem_write`=1, `mem_addr`=0, `mem_wdata`[95:64]=0xDEADBEEF.
  - After `mem_ready`: `mem_read`=1 with `mem_addr`=0x8, then the data is returned.
- Write miss: write 0x12345678 to addr 0x44 → fill of `mem_addr`=0x11, then stall=0; a read of 0x44 returns 0x12345678.
- Reset mid-ALLOCATE: `mem_read` drops immediately; the next read of 0x0 misses again with `mem_read`=1.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_W        = 2;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
  localparam int ADDR_W          = 30;
  localparam int MEM_ADDR_W      = ADDR_W - OFFSET_W;
endpackage

// File: rtl/dm_cache_if.sv
// Processor-side and memory-side bus of one cache instance.
interface dm_cache_if;
  import cache_pkg::*;

  logic [ADDR_W-1:0]     proc_addr;
  logic                  proc_ren;
  logic                  proc_wen;
  logic [WORD_W-1:0]     proc_wdata;
  logic [WORD_W-1:0]     proc_rdata;
  logic                  proc_stall;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [BLOCK_W-1:0]    mem_wdata;
  logic [BLOCK_W-1:0]    mem_rdata;
  logic                  mem_ready;

  // slave: the cache itself; master: processor plus memory around it
  modport slave (
    input  proc_addr, proc_ren, proc_wen, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_addr, mem_read, mem_write, mem_wdata
  );
  modport master (
    output proc_addr, proc_ren, proc_wen, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/dm_cache_line_array.sv
// Valid/dirty/tag/data storage: async read, sync fill or single-word write.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  i_idx,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [TAG_W-1:0]    o_tag,
  output logic [BLOCK_W-1:0]  o_data,
  input  logic                i_fill,
  input  logic [TAG_W-1:0]    i_fill_tag,
  input  logic [BLOCK_W-1:0]  i_fill_data,
  input  logic                i_wr_word,
  input  logic [OFFSET_W-1:0] i_wr_off,
  input  logic [WORD_W-1:0]   i_wr_data
);
  localparam int NBLK = 1 << INDEX_W;

  logic [NBLK-1:0]                             r_valid;
  logic [NBLK-1:0]                             r_dirty;
  logic [NBLK-1:0][TAG_W-1:0]                  r_tag;
  logic [NBLK-1:0][WORDS_PER_BLOCK-1:0][WORD_W-1:0] r_data;

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_word) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Payload is left unreset; valid gates any use of it.
  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_wr_word) begin
      r_data[i_idx][i_wr_off] <= i_wr_data;
    end
  end
endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back/write-allocate cache: FSM, hit compare, output muxing.
module dm_cache
  import cache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  dm_cache_if.slave  bus
);
  localparam int TAG_W = 28 - INDEX_W;

  state_e r_state, w_next;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFFSET_W-1:0] w_off;
  logic                w_req, w_hit;
  logic                w_lvalid, w_ldirty;
  logic [TAG_W-1:0]    w_ltag;
  logic [BLOCK_W-1:0]  w_ldata;
  logic                w_fill, w_wr_word;

  assign w_off = bus.proc_addr[OFFSET_W-1:0];
  assign w_idx = bus.proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_tag = bus.proc_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign w_req = bus.proc_ren | bus.proc_wen;
  assign w_hit = w_lvalid && (w_ltag == w_tag);

  // A write-miss merges its word on the IDLE hit that follows the fill.
  assign w_fill    = (r_state == ALLOCATE) && bus.mem_ready;
  assign w_wr_word = (r_state == IDLE) && bus.proc_wen && w_hit;

  cache_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_lines (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_idx       (w_idx),
    .o_valid     (w_lvalid),
    .o_dirty     (w_ldirty),
    .o_tag       (w_ltag),
    .o_data      (w_ldata),
    .i_fill      (w_fill),
    .i_fill_tag  (w_tag),
    .i_fill_data (bus.mem_rdata),
    .i_wr_word   (w_wr_word),
    .i_wr_off    (w_off),
    .i_wr_data   (bus.proc_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_req && !w_hit) w_next = (w_lvalid && w_ldirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (bus.mem_ready) w_next = ALLOCATE;
      ALLOCATE:  if (bus.mem_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        bus.proc_stall = w_req && !w_hit;
        if (bus.proc_ren && !bus.proc_wen && w_hit)
          bus.proc_rdata = w_ldata[WORD_W*w_off +: WORD_W];
      end
      WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {w_ltag, w_idx};
        bus.mem_wdata  = w_ldata;
      end
      ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = bus.proc_addr[ADDR_W-1:OFFSET_W];
      end
      default: bus.proc_stall = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_dm_cache.sv
// Directed checks of dm_cache: hits, clean/dirty misses, write-miss merge, reset abort.
module tb_dm_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dm_cache_if bif();
  dm_cache #(.INDEX_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [29:0] a, input logic r, input logic w, input logic [31:0] d);
    bif.proc_addr  = a;
    bif.proc_ren   = r;
    bif.proc_wen   = w;
    bif.proc_wdata = d;
    #1;
  endtask

  initial begin
    bif.proc_addr = '0; bif.proc_ren = 0; bif.proc_wen = 0; bif.proc_wdata = '0;
    bif.mem_rdata = '0; bif.mem_ready = 0;
    #3;
    chk("rst_stall", bif.proc_stall, 0);
    chk("rst_mread", bif.mem_read, 0);
    chk("rst_mwrite", bif.mem_write, 0);
    chk("rst_maddr", bif.mem_addr, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // clean read miss at 0x0, memory answers on third ALLOCATE cycle
    req(30'h0, 1, 0, 0);
    chk("miss0_stall", bif.proc_stall, 1);
    chk("miss0_mread_c0", bif.mem_read, 0);
    tick();
    chk("miss0_mread", bif.mem_read, 1);
    chk("miss0_maddr", bif.mem_addr, 28'h0);
    chk("miss0_stall1", bif.proc_stall, 1);
    tick();
    chk("miss0_stall2", bif.proc_stall, 1);
    tick();
    bif.mem_rdata = 128'h00000004_00000003_00000002_00000001;
    bif.mem_ready = 1; #1;
    chk("miss0_mread3", bif.mem_read, 1);
    tick();
    bif.mem_ready = 0; bif.mem_rdata = '0; #1;
    chk("fill0_stall", bif.proc_stall, 0);
    chk("fill0_rdata", bif.proc_rdata, 32'h1);
    chk("fill0_mread", bif.mem_read, 0);

    // read hit, same block
    tick();
    req(30'h1, 1, 0, 0);
    chk("hit1_stall", bif.proc_stall, 0);
    chk("hit1_rdata", bif.proc_rdata, 32'h2);
    chk("hit1_mem", {bif.mem_read, bif.mem_write}, 0);

    // stray mem_ready in IDLE is ignored
    bif.mem_ready = 1; #1;
    tick();
    bif.mem_ready = 0; #1;
    chk("stray_stall", bif.proc_stall, 0);
    chk("stray_mread", bif.mem_read, 0);

    // write hit then read back
    req(30'h2, 0, 1, 32'hDEADBEEF);
    chk("whit_stall", bif.proc_stall, 0);
    chk("whit_mem", {bif.mem_read, bif.mem_write}, 0);
    tick();
    req(30'h2, 1, 0, 0);
    chk("whit_rb", bif.proc_rdata, 32'hDEADBEEF);
    tick();

    // dirty conflict miss at 0x20 (index 0, tag 1)
    req(30'h20, 1, 0, 0);
    chk("dirty_stall", bif.proc_stall, 1);
    tick();
    chk("wb_mwrite", bif.mem_write, 1);
    chk("wb_mread", bif.mem_read, 0);
    chk("wb_maddr", bif.mem_addr, 28'h0);
    chk("wb_word2", bif.mem_wdata[95:64], 32'hDEADBEEF);
    chk("wb_block", bif.mem_wdata, 128'h00000004_DEADBEEF_00000002_00000001);
    bif.mem_ready = 1; #1;
    tick();
    bif.mem_ready = 0; #1;
    chk("al20_mread", bif.mem_read, 1);
    chk("al20_mwrite", bif.mem_write, 0);
    chk("al20_maddr", bif.mem_addr, 28'h8);
    bif.mem_rdata = 128'h44444444_33333333_22222222_11111111;
    bif.mem_ready = 1; #1;
    tick();
    bif.mem_ready = 0; bif.mem_rdata = '0; #1;
    chk("fill20_stall", bif.proc_stall, 0);
    chk("fill20_rdata", bif.proc_rdata, 32'h11111111);
    tick();

    // write miss at 0x44 (index 1): fill, then merge
    req(30'h44, 0, 1, 32'h12345678);
    chk("wmiss_stall", bif.proc_stall, 1);
    tick();
    chk("wmiss_mread", bif.mem_read, 1);
    chk("wmiss_maddr", bif.mem_addr, 28'h11);
    bif.mem_rdata = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    bif.mem_ready = 1; #1;
    tick();
    bif.mem_ready = 0; bif.mem_rdata = '0; #1;
    chk("wmiss_merge_stall", bif.proc_stall, 0);
    tick();
    req(30'h44, 1, 0, 0);
    chk("wmiss_rb", bif.proc_rdata, 32'h12345678);
    req(30'h45, 1, 0, 0);
    chk("wmiss_rb1", bif.proc_rdata, 32'hA1A1A1A1);
    tick();

    // both ren and wen high acts as write
    req(30'h47, 1, 1, 32'hCAFEF00D);
    chk("rw_stall", bif.proc_stall, 0);
    chk("rw_rdata", bif.proc_rdata, 32'h0);
    tick();
    req(30'h47, 1, 0, 0);
    chk("rw_rb", bif.proc_rdata, 32'hCAFEF00D);
    tick();

    // reset during ALLOCATE of 0x0 (line 0 holds tag 1, clean)
    req(30'h0, 1, 0, 0);
    chk("rmiss_stall", bif.proc_stall, 1);
    tick();
    chk("rmiss_mread", bif.mem_read, 1);
    rst_n = 1'b0; #1;
    chk("rabort_mread", bif.mem_read, 0);
    chk("rabort_maddr", bif.mem_addr, 28'h0);
    tick();
    rst_n = 1'b1; #1;
    chk("rpost_stall", bif.proc_stall, 1);
    tick();
    chk("rpost_mread", bif.mem_read, 1);
    chk("rpost_maddr", bif.mem_addr, 28'h0);
    bif.mem_rdata = 128'h00000004_00000003_00000002_00000001;
    bif.mem_ready = 1; #1;
    tick();
    bif.mem_ready = 0; bif.mem_rdata = '0; #1;
    chk("rpost_rdata", bif.proc_rdata, 32'h1);
    chk("rpost_stall2", bif.proc_stall, 0);
    req(30'h44, 1, 0, 0);
    chk("rpost_inval", bif.proc_stall, 1);
    req(30'h0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
